// File: rtl/merger_pkg.sv
// Shared definitions for every 2-to-1 merger node in the merger tree.
// Contents:
//   merge_state_e  : sequencer states
//   *_DEF          : default key/tuple/run-length widths used by all nodes
//   is_term()      : terminator test (a tuple whose bits are all zero)
package merger_pkg;

  localparam int KEY_WIDTH_DEF  = 80;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int LEN_WIDTH_DEF  = 32;
  // Widest tuple is_term() accepts; narrower tuples are zero-extended by the caller.
  localparam int MAX_DATA_WIDTH = 512;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MERGE   = 3'd1,
    DRAIN_A = 3'd2,
    DRAIN_B = 3'd3,
    TERM    = 3'd4
  } merge_state_e;

  // A zero tuple marks the end of a sorted run.
  function automatic logic is_term(input logic [MAX_DATA_WIDTH-1:0] tuple);
    return (tuple == {MAX_DATA_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/merge_select_fsm_if.sv
// Handshake bundle between a merger node's FIFO pair / bitonic network and its sequencer.
// Inputs  : i_a_head, i_b_head (show-ahead low tuples), i_a_empty, i_b_empty, i_out_full
// Outputs : o_deq_a, o_deq_b, o_push, o_select_a, o_stall (same-cycle),
//           o_switch_output, o_run_done, o_run_len (registered)
// Modports: slave = sequencer side, master = FIFO/network (or bench) side.
interface merge_select_fsm_if #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] i_a_head;
  logic [DATA_WIDTH-1:0] i_b_head;
  logic                  i_a_empty;
  logic                  i_b_empty;
  logic                  i_out_full;
  logic                  o_deq_a;
  logic                  o_deq_b;
  logic                  o_push;
  logic                  o_select_a;
  logic                  o_switch_output;
  logic                  o_stall;
  logic                  o_run_done;
  logic [LEN_WIDTH-1:0]  o_run_len;

  modport slave (
    input  i_a_head, i_b_head, i_a_empty, i_b_empty, i_out_full,
    output o_deq_a, o_deq_b, o_push, o_select_a, o_switch_output,
           o_stall, o_run_done, o_run_len
  );

  modport master (
    output i_a_head, i_b_head, i_a_empty, i_b_empty, i_out_full,
    input  o_deq_a, o_deq_b, o_push, o_select_a, o_switch_output,
           o_stall, o_run_done, o_run_len
  );
endinterface

// File: rtl/merge_select_fsm_run_counter.sv
// Run-length bookkeeping for one merger node.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push         : a block enters the network this cycle
//   i_term_push    : the pushed block is the run terminator
//   o_run_done     : registered one-cycle pulse after the terminator push
//   o_run_len      : blocks in the finished run (terminator included), held until next done
module merge_run_counter #(
  parameter int LEN_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic                 i_term_push,
  output logic                 o_run_done,
  output logic [LEN_WIDTH-1:0] o_run_len
);

  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] cnt_inc_s;
  logic                 run_done_r;
  logic [LEN_WIDTH-1:0] run_len_r;

  // Saturating increment: a very long run pins at all-ones instead of wrapping.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r == {LEN_WIDTH{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + LEN_WIDTH'(1);
    end
  end

  // Count pushes; the terminator push latches the total and restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r      <= {LEN_WIDTH{1'b0}};
      run_len_r  <= {LEN_WIDTH{1'b0}};
      run_done_r <= 1'b0;
    end else begin
      run_done_r <= i_push & i_term_push;
      if (i_push) begin
        if (i_term_push) begin
          run_len_r <= cnt_inc_s;
          cnt_r     <= {LEN_WIDTH{1'b0}};
        end else begin
          cnt_r     <= cnt_inc_s;
        end
      end
    end
  end

  assign o_run_done = run_done_r;
  assign o_run_len  = run_len_r;

endmodule

// File: rtl/merge_select_fsm.sv
// Sequencer for one 2-to-1 merger node: picks the smaller FIFO head each cycle,
// drains the surviving FIFO once the other shows its terminator, emits a single
// terminator per run and keeps the network's output-half tag in step.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : FIFO heads/empties, downstream full, dequeue/push/select/stall
//                    strobes, switch_output tag, run done pulse and length
module merge_select_fsm
  import merger_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  merge_select_fsm_if.slave  bus
);

  merge_state_e state_r;
  merge_state_e state_next_s;
  logic         za_s;
  logic         zb_s;
  logic         a_lte_b_s;
  logic         deq_a_s;
  logic         deq_b_s;
  logic         push_s;
  logic         sel_a_s;
  logic         term_push_s;
  logic         toggle_s;
  logic         switch_r;
  logic         last_sel_r;
  logic         first_r;

  assign za_s      = is_term(MAX_DATA_WIDTH'(bus.i_a_head));
  assign zb_s      = is_term(MAX_DATA_WIDTH'(bus.i_b_head));
  assign a_lte_b_s = (bus.i_a_head[KEY_WIDTH-1:0] <= bus.i_b_head[KEY_WIDTH-1:0]);

  // Next-state and same-cycle strobes; downstream full freezes everything.
  always_comb begin
    state_next_s = state_r;
    deq_a_s      = 1'b0;
    deq_b_s      = 1'b0;
    push_s       = 1'b0;
    sel_a_s      = 1'b0;
    term_push_s  = 1'b0;
    if (bus.i_out_full) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.i_a_empty && !bus.i_b_empty) begin
            state_next_s = MERGE;
          end else begin
            state_next_s = IDLE;
          end
        end
        MERGE: begin
          // A terminator head is never dequeued here; we only change state on it.
          if (bus.i_a_empty || bus.i_b_empty) begin
            state_next_s = MERGE;
          end else if (za_s && zb_s) begin
            state_next_s = TERM;
          end else if (za_s) begin
            state_next_s = DRAIN_B;
          end else if (zb_s) begin
            state_next_s = DRAIN_A;
          end else begin
            push_s  = 1'b1;
            sel_a_s = a_lte_b_s;
            deq_a_s = a_lte_b_s;
            deq_b_s = ~a_lte_b_s;
          end
        end
        DRAIN_A: begin
          if (bus.i_a_empty) begin
            state_next_s = DRAIN_A;
          end else if (za_s) begin
            state_next_s = TERM;
          end else begin
            push_s  = 1'b1;
            sel_a_s = 1'b1;
            deq_a_s = 1'b1;
          end
        end
        DRAIN_B: begin
          if (bus.i_b_empty) begin
            state_next_s = DRAIN_B;
          end else if (zb_s) begin
            state_next_s = TERM;
          end else begin
            push_s  = 1'b1;
            sel_a_s = 1'b0;
            deq_b_s = 1'b1;
          end
        end
        TERM: begin
          // Both terminators leave together; only A's copy goes downstream.
          push_s       = 1'b1;
          sel_a_s      = 1'b1;
          deq_a_s      = 1'b1;
          deq_b_s      = 1'b1;
          term_push_s  = 1'b1;
          state_next_s = IDLE;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // The first push of a run counts as a source change only when it comes from B.
  always_comb begin
    toggle_s = 1'b0;
    if (first_r) begin
      toggle_s = ~sel_a_s;
    end else begin
      toggle_s = (sel_a_s != last_sel_r);
    end
  end

  // State register plus switch_output tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      switch_r   <= 1'b0;
      last_sel_r <= 1'b0;
      first_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (push_s) begin
        last_sel_r <= sel_a_s;
        if (term_push_s) begin
          switch_r <= 1'b0;
          first_r  <= 1'b1;
        end else begin
          first_r <= 1'b0;
          if (toggle_s) begin
            switch_r <= ~switch_r;
          end
        end
      end
    end
  end

  logic                 run_done_s;
  logic [LEN_WIDTH-1:0] run_len_s;

  merge_run_counter #(.LEN_WIDTH(LEN_WIDTH)) u_run_counter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push_s),
    .i_term_push (term_push_s),
    .o_run_done  (run_done_s),
    .o_run_len   (run_len_s)
  );

  assign bus.o_deq_a         = deq_a_s;
  assign bus.o_deq_b         = deq_b_s;
  assign bus.o_push          = push_s;
  assign bus.o_select_a      = sel_a_s;
  assign bus.o_stall         = ~push_s;
  assign bus.o_switch_output = switch_r;
  assign bus.o_run_done      = run_done_s;
  assign bus.o_run_len       = run_len_s;

endmodule

// File: tb/tb_merge_select_fsm.sv
// Scoreboard bench for merge_select_fsm: directed runs push expected push-events and
// run lengths into queues; a negedge monitor pops and compares whenever the DUT pushes
// or pulses run_done. A small FIFO model feeds the heads and honours the dequeues.
module tb_merge_select_fsm;

  localparam int DW = 128;
  localparam int LW = 3;

  typedef struct packed {
    logic sel;
    logic da;
    logic db;
    logic sw;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          hold_a;
  logic          fifo_da;
  logic          fifo_db;
  exp_t          exp_q[$];
  logic [LW-1:0] exp_len_q[$];

  merge_select_fsm_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) mif ();

  merge_select_fsm #(.KEY_WIDTH(80), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_heads();
    mif.i_a_head  = (qa.size() != 0) ? qa[0] : {DW{1'b0}};
    mif.i_b_head  = (qb.size() != 0) ? qb[0] : {DW{1'b0}};
    mif.i_a_empty = (qa.size() == 0) || hold_a;
    mif.i_b_empty = (qb.size() == 0);
  endtask

  task automatic expect_push(input logic sel, input logic da, input logic db, input logic sw);
    exp_t e;
    e.sel = sel; e.da = da; e.db = db; e.sw = sw;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && exp_len_q.size() == 0) break;
      step();
    end
    check({name, "_drained"}, exp_q.size() + exp_len_q.size(), 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    step();
    step();
  endtask

  // FIFO model: dequeue on the edge the DUT asked for it, then present the new heads.
  always @(posedge clk) begin
    fifo_da = mif.o_deq_a;
    fifo_db = mif.o_deq_b;
    #1;
    if (fifo_da && qa.size() != 0) void'(qa.pop_front());
    if (fifo_db && qb.size() != 0) void'(qb.pop_front());
    drive_heads();
  end

  // Monitor: compares every push and every run_done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    check("stall_vs_push", {31'd0, mif.o_stall}, {31'd0, ~mif.o_push});
    if (mif.i_out_full) begin
      check("full_blocks", {29'd0, mif.o_push, mif.o_deq_a, mif.o_deq_b}, 32'd0);
    end
    if (!mif.o_push && (mif.o_deq_a || mif.o_deq_b)) begin
      check("deq_without_push", 32'd1, 32'd0);
    end
    if (mif.o_push) begin
      if (exp_q.size() == 0) begin
        check("unexpected_push", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("select_a", {31'd0, mif.o_select_a}, {31'd0, e.sel});
        check("deq_a", {31'd0, mif.o_deq_a}, {31'd0, e.da});
        check("deq_b", {31'd0, mif.o_deq_b}, {31'd0, e.db});
        check("switch_output", {31'd0, mif.o_switch_output}, {31'd0, e.sw});
      end
    end
    if (mif.o_run_done) begin
      if (exp_len_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("run_len", {29'd0, mif.o_run_len}, {29'd0, exp_len_q.pop_front()});
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hold_a   = 1'b0;
    mif.i_out_full = 1'b0;
    drive_heads();
    rst_n = 1'b0;
    #13;
    check("rst_stall", {31'd0, mif.o_stall}, 32'd1);
    check("rst_push", {31'd0, mif.o_push}, 32'd0);
    check("rst_switch", {31'd0, mif.o_switch_output}, 32'd0);
    check("rst_run_len", {29'd0, mif.o_run_len}, 32'd0);
    check("rst_done", {31'd0, mif.o_run_done}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: reset mid-MERGE discards the run (B2 pushed first so switch_output is 1).
    qa = '{128'd5, 128'd0};
    qb = '{128'd2, 128'd3, 128'd0};
    drive_heads();
    expect_push(1'b0, 1'b0, 1'b1, 1'b0);
    step();                        // IDLE -> MERGE, B2 pushed during this cycle
    step();                        // B2 dequeued, switch_output now 1
    mif.i_out_full = 1'b1;         // freeze in MERGE
    check("pre_rst_switch", {31'd0, mif.o_switch_output}, 32'd1);
    step();
    rst_n = 1'b0;
    mif.i_out_full = 1'b0;
    qa.delete();
    qb.delete();
    drive_heads();
    #1;
    check("midrun_rst_stall", {31'd0, mif.o_stall}, 32'd1);
    check("midrun_rst_push", {31'd0, mif.o_push}, 32'd0);
    check("midrun_rst_switch", {31'd0, mif.o_switch_output}, 32'd0);
    step();
    rst_n = 1'b1;
    check("midrun_rst_scoreboard", exp_q.size(), 32'd0);
    step();

    // 2: basic merge, A 1,4,T and B 2,3,T -> A,B,B,A,term.
    qa = '{128'd1, 128'd4, 128'd0};
    qb = '{128'd2, 128'd3, 128'd0};
    drive_heads();
    expect_push(1'b1, 1'b1, 1'b0, 1'b0);
    expect_push(1'b0, 1'b0, 1'b1, 1'b0);
    expect_push(1'b0, 1'b0, 1'b1, 1'b1);
    expect_push(1'b1, 1'b1, 1'b0, 1'b1);
    expect_push(1'b1, 1'b1, 1'b1, 1'b0);
    exp_len_q.push_back(3'd5);
    wait_drain("basic");

    // 3: tie goes to A; switch toggles only on source change.
    qa = '{128'd7, 128'd9, 128'd0};
    qb = '{128'd7, 128'd0};
    drive_heads();
    expect_push(1'b1, 1'b1, 1'b0, 1'b0);
    expect_push(1'b0, 1'b0, 1'b1, 1'b0);
    expect_push(1'b1, 1'b1, 1'b0, 1'b1);
    expect_push(1'b1, 1'b1, 1'b1, 1'b0);
    exp_len_q.push_back(3'd4);
    wait_drain("tie");

    // 4: early terminator on A -> drain B, then joint terminator dequeue.
    qa = '{128'd0};
    qb = '{128'd5, 128'd6, 128'd0};
    drive_heads();
    expect_push(1'b0, 1'b0, 1'b1, 1'b0);
    expect_push(1'b0, 1'b0, 1'b1, 1'b1);
    expect_push(1'b1, 1'b1, 1'b1, 1'b1);
    exp_len_q.push_back(3'd3);
    wait_drain("early_term");

    // 5: backpressure for 3 cycles while in MERGE.
    qa = '{128'd2, 128'd5, 128'd0};
    qb = '{128'd3, 128'd0};
    drive_heads();
    step();                        // IDLE -> MERGE
    mif.i_out_full = 1'b1;
    repeat (3) step();
    check("bp_switch_held", {31'd0, mif.o_switch_output}, 32'd0);
    check("bp_nothing_dequeued", qa.size() + qb.size(), 32'd5);
    mif.i_out_full = 1'b0;
    expect_push(1'b1, 1'b1, 1'b0, 1'b0);
    expect_push(1'b0, 1'b0, 1'b1, 1'b0);
    expect_push(1'b1, 1'b1, 1'b0, 1'b1);
    expect_push(1'b1, 1'b1, 1'b1, 1'b0);
    exp_len_q.push_back(3'd4);
    wait_drain("backpressure");

    // 6: A empty for 2 cycles in DRAIN_A; 9 pushes saturate the 3-bit length at 7.
    qa = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7, 128'd8, 128'd0};
    qb = '{128'd0};
    drive_heads();
    for (int i = 0; i < 8; i++) expect_push(1'b1, 1'b1, 1'b0, 1'b0);
    expect_push(1'b1, 1'b1, 1'b1, 1'b0);
    exp_len_q.push_back(3'd7);
    step();                        // IDLE -> MERGE
    step();                        // MERGE -> DRAIN_A
    step();
    hold_a = 1'b1;
    drive_heads();
    #1;
    check("drain_empty_push", {31'd0, mif.o_push}, 32'd0);
    check("drain_empty_stall", {31'd0, mif.o_stall}, 32'd1);
    step();
    step();
    hold_a = 1'b0;
    drive_heads();
    wait_drain("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
